// File: rtl/perceptron_core.sv
`timescale 1ns/1ps
// perceptron_core
// Single-neuron perceptron: signed fixed-point MAC over N_IN inputs plus a bias,
// selectable hard activation, and an optional in-place training step.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a transaction (sampled only in IDLE)
//   train, act_sel      latched with start; act_sel 0 Step, 1 Sigmoid, 2 Tanh, 3 ReLU
//   x_flat              input vector, x[i] = x_flat[i*W +: W]; latched with start
//   target              training target; latched with start
//   w_load/w_idx/w_data weight write port (IDLE only); index N_IN is the bias
//   rd_idx/rd_data      combinational weight readback, 0 when rd_idx > N_IN
//   busy                high in every state except IDLE
//   done                one-cycle pulse at the end of a transaction
//   y, err              activation output and training error (held between updates)
module perceptron_core #(
  parameter int N_IN     = 4,
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int LR_SHIFT = 4,
  localparam int IW      = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              train,
  input  logic [1:0]        act_sel,
  input  logic [N_IN*W-1:0] x_flat,
  input  logic [W-1:0]      target,
  input  logic              w_load,
  input  logic [IW-1:0]     w_idx,
  input  logic [W-1:0]      w_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [W-1:0]      rd_data,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      y,
  output logic [W-1:0]      err
);

  // Intermediate sums are carried at 2W+1 bits so a 2W-bit product plus a
  // W-bit accumulator can never wrap before saturation.
  localparam int SW = 2*W + 1;

  localparam logic signed [W-1:0] ONE     = W'(1) << FRAC;
  localparam logic signed [W-1:0] NEG_ONE = -ONE;
  localparam logic signed [W-1:0] HALF    = ONE >>> 1;
  localparam logic signed [W-1:0] MAXW    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINW    = {1'b1, {(W-1){1'b0}}};
  localparam logic [IW-1:0]       LAST    = IW'(N_IN);
  localparam logic [IW-1:0]       LASTX   = IW'(N_IN - 1);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_FIN} state_t;

  state_t state, nstate;

  logic [N_IN:0][W-1:0]   wmem;     // [N_IN] is the bias
  logic [N_IN-1:0][W-1:0] x_lat;
  logic [W-1:0]           tgt_lat;
  logic [1:0]             act_lat;
  logic                   trn_lat;
  logic signed [W-1:0]    acc;
  logic [IW-1:0]          cnt;

  function automatic logic [W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SW'(MAXW))      sat = MAXW;
    else if (v < SW'(MINW)) sat = MINW;
    else                    sat = v[W-1:0];
  endfunction

  // Operand selection by explicit compare so any N_IN works without
  // out-of-range array indexing.
  logic signed [W-1:0] w_sel, x_sel;
  always_comb begin
    w_sel   = '0;
    x_sel   = '0;
    rd_data = '0;
    for (int j = 0; j <= N_IN; j++) begin
      if (cnt == IW'(j))    w_sel   = wmem[j];
      if (rd_idx == IW'(j)) rd_data = wmem[j];
    end
    for (int j = 0; j < N_IN; j++)
      if (cnt == IW'(j)) x_sel = x_lat[j];
  end

  // MAC step
  logic signed [2*W-1:0] prod;
  logic signed [SW-1:0]  mac_sum;
  logic [W-1:0]          acc_next;
  assign prod     = (2*W)'(w_sel) * (2*W)'(x_sel);
  assign mac_sum  = SW'(acc) + SW'(prod >>> FRAC);
  assign acc_next = sat(mac_sum);

  // Activation and error
  logic signed [SW-1:0] sg;
  logic signed [W-1:0]  y_next;
  logic [W-1:0]         err_next;
  always_comb begin
    sg     = SW'(HALF) + SW'(acc >>> 2);
    y_next = '0;
    case (act_lat)
      2'd0: y_next = acc[W-1] ? '0 : ONE;
      2'd1: begin
        if (sg < 0)              y_next = '0;
        else if (sg > SW'(ONE))  y_next = ONE;
        else                     y_next = sg[W-1:0];
      end
      2'd2: begin
        if (acc > ONE)           y_next = ONE;
        else if (acc < NEG_ONE)  y_next = NEG_ONE;
        else                     y_next = acc;
      end
      default: y_next = acc[W-1] ? '0 : acc;
    endcase
    err_next = sat(SW'($signed(tgt_lat)) - SW'(y_next));
  end

  // Weight update; the last update slot is the bias, which has no input term.
  logic signed [2*W-1:0] eprod;
  logic signed [SW-1:0]  upd_inc, upd_sum;
  logic [W-1:0]          w_new;
  assign eprod   = (2*W)'($signed(err)) * (2*W)'(x_sel);
  assign upd_inc = (cnt == LAST) ? SW'($signed(err) >>> LR_SHIFT)
                                 : SW'(eprod >>> (FRAC + LR_SHIFT));
  assign upd_sum = SW'(w_sel) + upd_inc;
  assign w_new   = sat(upd_sum);

  // FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;

  always_comb begin
    nstate = state;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nstate = S_MAC;
      end
      S_MAC:   if (cnt == LASTX) nstate = S_ACT;
      S_ACT:   nstate = trn_lat ? S_UPD : S_FIN;
      S_UPD:   if (cnt == LAST) nstate = S_FIN;
      S_FIN: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmem    <= '0;
      x_lat   <= '0;
      tgt_lat <= '0;
      act_lat <= '0;
      trn_lat <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      y       <= '0;
      err     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_load)
            for (int j = 0; j <= N_IN; j++)
              if (w_idx == IW'(j)) wmem[j] <= w_data;
          if (start) begin
            x_lat   <= x_flat;
            tgt_lat <= target;
            act_lat <= act_sel;
            trn_lat <= train;
            cnt     <= '0;
            // a bias write landing on the same edge must seed the accumulator
            acc     <= (w_load && w_idx == LAST) ? w_data : wmem[N_IN];
          end
        end
        S_MAC: begin
          acc <= acc_next;
          cnt <= (cnt == LASTX) ? '0 : cnt + IW'(1);
        end
        S_ACT: begin
          y   <= y_next;
          if (trn_lat) err <= err_next;
          cnt <= '0;
        end
        S_UPD: begin
          for (int j = 0; j <= N_IN; j++)
            if (cnt == IW'(j)) wmem[j] <= w_new;
          cnt <= cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_core.sv
`timescale 1ns/1ps
// Scoreboarded bench for perceptron_core (default parameters).
// Stimulus tasks push the reference model's expected y/err/done-cycle into a
// queue; an independent monitor pops and compares on every done pulse.
module tb_perceptron_core;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 3;
  localparam longint ONE  = 64'sd65536;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, train = 1'b0;
  logic [1:0]    act_sel = '0;
  logic [N*W-1:0] x_flat = '0;
  logic [W-1:0]  target = '0, w_data = '0;
  logic          w_load = 1'b0;
  logic [IW-1:0] w_idx = '0, rd_idx = '0;
  logic [W-1:0]  rd_data, y, err;
  logic          busy, done;

  perceptron_core #(.N_IN(N), .W(W), .FRAC(16), .LR_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train(train), .act_sel(act_sel),
    .x_flat(x_flat), .target(target), .w_load(w_load), .w_idx(w_idx),
    .w_data(w_data), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy),
    .done(done), .y(y), .err(err)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] y; logic [31:0] e; int unsigned c; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;
  longint mw[0:N];
  longint m_err = 0;
  longint tx[0:N-1];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [31:0] rnd();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 32'h80000)) - 32'h40000;
  endfunction

  // Reference: weighted sum with per-step saturation, activation, then update.
  task automatic model(input logic [1:0] a, input bit tr, input longint tg,
                       output logic [31:0] ey, output logic [31:0] ee);
    longint acc, yv;
    acc = mw[N];
    for (int i = 0; i < N; i++) acc = sat(acc + ((mw[i] * tx[i]) >>> 16));
    case (a)
      2'd0: yv = (acc >= 0) ? ONE : 0;
      2'd1: begin
        yv = ONE / 2 + (acc >>> 2);
        if (yv < 0) yv = 0;
        if (yv > ONE) yv = ONE;
      end
      2'd2: yv = (acc > ONE) ? ONE : (acc < -ONE) ? -ONE : acc;
      default: yv = (acc > 0) ? acc : 0;
    endcase
    if (tr) begin
      m_err = sat(tg - yv);
      for (int i = 0; i < N; i++) mw[i] = sat(mw[i] + (((m_err * tx[i]) >>> 16) >>> 4));
      mw[N] = sat(mw[N] + (m_err >>> 4));
    end
    ey = yv[31:0];
    ee = m_err[31:0];
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic wload(input logic [IW-1:0] idx, input logic [31:0] d);
    w_load = 1'b1; w_idx = idx; w_data = d;
    @(negedge clk);
    w_load = 1'b0;
    if (idx <= IW'(N)) mw[idx] = s32(d);
  endtask

  task automatic issue(input logic [1:0] a, input bit tr, input logic [31:0] tg,
                       input bit ld, input logic [IW-1:0] li, input logic [31:0] ldd,
                       input bit poke);
    exp_t e;
    for (int i = 0; i < N; i++) x_flat[i*W +: W] = tx[i][31:0];
    act_sel = a; train = tr; target = tg; start = 1'b1;
    if (ld) begin
      w_load = 1'b1; w_idx = li; w_data = ldd;
      if (li <= IW'(N)) mw[li] = s32(ldd);
    end
    model(a, tr, s32(tg), e.y, e.e);
    e.c = cyc + 1 + (tr ? 2*N + 2 : N + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; w_load = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (poke) begin
      // both must be dropped while busy
      start = 1'b1; act_sel = 2'($urandom); x_flat[W-1:0] = $urandom;
      w_load = 1'b1; w_idx = '0; w_data = $urandom;
      @(negedge clk);
      start = 1'b0; w_load = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    chk("idle_wait", 32'(ok), 32'd1);
    if (!ok) sb.delete();
  endtask

  task automatic chk_w();
    for (int j = 0; j <= N; j++) begin
      rd_idx = IW'(j);
      #1;
      chk($sformatf("rd_w%0d", j), rd_data, mw[j][31:0]);
    end
  endtask

  task automatic set_w(input logic [31:0] w0, w1, w2, w3, b);
    wload(3'd0, w0); wload(3'd1, w1); wload(3'd2, w2); wload(3'd3, w3); wload(3'd4, b);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("y", y, e.y);
          chk("err", err, e.e);
          chk("done_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    for (int j = 0; j <= N; j++) mw[j] = 0;
    for (int i = 0; i < N; i++) tx[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", y, 32'd0);
    for (int j = 0; j < 8; j++) begin
      rd_idx = IW'(j); #1;
      chk($sformatf("rst_rd%0d", j), rd_data, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // ReLU inference, with a dropped start/w_load while busy
    set_w(32'h10000, 32'h20000, 32'hFFFF0000, 32'h8000, 32'h4000);
    tx[0] = ONE; tx[1] = ONE; tx[2] = ONE; tx[3] = 2*ONE;
    issue(2'd3, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1);
    wait_idle();
    chk("relu_y_const", y, 32'h34000);

    // Activations at acc = 2.0 and acc = -1.0
    set_w(32'h10000, 0, 0, 0, 0);
    tx[0] = 2*ONE; tx[1] = 0; tx[2] = 0; tx[3] = 0;
    issue(2'd1, 0, 0, 0, 0, 0, 0); wait_idle(); chk("sig_p2", y, 32'h10000);
    issue(2'd2, 0, 0, 0, 0, 0, 0); wait_idle(); chk("tanh_p2", y, 32'h10000);
    issue(2'd0, 0, 0, 0, 0, 0, 0); wait_idle(); chk("step_p2", y, 32'h10000);
    tx[0] = -ONE;
    issue(2'd1, 0, 0, 0, 0, 0, 0); wait_idle(); chk("sig_m1", y, 32'h4000);
    issue(2'd2, 0, 0, 0, 0, 0, 0); wait_idle(); chk("tanh_m1", y, 32'hFFFF0000);
    issue(2'd3, 0, 0, 0, 0, 0, 0); wait_idle(); chk("relu_m1", y, 32'h0);

    // Training step from zero weights
    set_w(0, 0, 0, 0, 0);
    tx[0] = ONE;
    issue(2'd3, 1'b1, 32'h10000, 0, 0, 0, 0);
    wait_idle();
    chk("train_y", y, 32'h0);
    chk("train_err", err, 32'h10000);
    rd_idx = 3'd0; #1; chk("train_w0", rd_data, 32'h1000);
    rd_idx = 3'd4; #1; chk("train_bias", rd_data, 32'h1000);
    chk_w();

    // Saturation
    set_w(32'h7FFF0000, 0, 0, 0, 0);
    tx[0] = 64'sh7FFF0000;
    issue(2'd3, 0, 0, 0, 0, 0, 0); wait_idle(); chk("sat_relu", y, 32'h7FFFFFFF);
    issue(2'd2, 0, 0, 0, 0, 0, 0); wait_idle(); chk("sat_tanh", y, 32'h10000);

    // Load/start collision on the bias, then out-of-range write
    set_w(0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) tx[i] = ONE;
    issue(2'd3, 0, 0, 1'b1, 3'd4, 32'h20000, 0);
    wait_idle();
    chk("collide_y", y, 32'h20000);
    wload(3'd5, 32'h12345678);
    rd_idx = 3'd5; #1; chk("rd_oob", rd_data, 32'h0);
    chk_w();

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j <= N; j++)
        if ($urandom_range(0, 2) == 0) wload(IW'(j), rnd());
      for (int i = 0; i < N; i++) tx[i] = s32(rnd());
      issue(2'($urandom), 1'($urandom), rnd(), 1'($urandom_range(0, 3) == 0),
            IW'($urandom_range(0, 5)), rnd(), 1'($urandom));
      wait_idle();
      chk_w();
    end

    // Reset in the middle of MAC
    set_w(32'h10000, 32'h20000, 32'hFFFF0000, 32'h8000, 32'h4000);
    tx[0] = ONE; tx[1] = ONE; tx[2] = ONE; tx[3] = 2*ONE;
    issue(2'd3, 1'b1, 32'h50000, 0, 0, 0, 0);
    rst_n = 1'b0;
    sb.delete();
    for (int j = 0; j <= N; j++) mw[j] = 0;
    m_err = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_y", y, 32'd0);
    chk("mid_rst_err", err, 32'd0);
    for (int j = 0; j < 8; j++) begin
      rd_idx = IW'(j); #1;
      chk($sformatf("mid_rst_rd%0d", j), rd_data, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Recovery after reset
    set_w(32'h8000, 32'h10000, 0, 32'hFFFF8000, 32'h2000);
    for (int i = 0; i < N; i++) tx[i] = s32(rnd());
    issue(2'd3, 1'b1, 32'h8000, 0, 0, 0, 0);
    wait_idle();
    chk_w();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_core.md
# perceptron_core

Parametrised single-neuron perceptron engine with on-chip weight storage, selectable activation and an optional in-place training step. It accepts one input vector per transaction, computes the weighted sum with one signed fixed-point multiply-accumulate per cycle, applies the selected activation, and, in train mode, updates the weights and bias from the error. It generalises the team's fixed 64-bit Q32.32 arithmetic to arbitrary word width and fraction bits. It sits under the layer controller, which loads weights, issues `start` and collects `y`/`err`.

## Interface
- `N_IN`, 4, number of inputs; the weight store holds N_IN weights plus one bias at index N_IN
- `W`, 32, word width of all fixed-point values (signed two's complement)
- `FRAC`, 16, fraction bits; ONE = 1<<FRAC
- `LR_SHIFT`, 4, learning rate expressed as 2^-LR_SHIFT
- `clk` in 1: single clock, all logic on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a transaction; sampled only in IDLE
- `train` in 1: latched with `start`; 1 = infer then update weights
- `act_sel` in 2: latched with `start`; 0 Step, 1 Sigmoid (hard), 2 Tanh (hard), 3 ReLU
- `x_flat` in N_IN*W: input vector, x[i] = bits [i*W +: W]; latched with `start`
- `target` in W: training target; latched with `start`
- `w_load` in 1: write `w_data` to weight `w_idx`; honoured only in IDLE
- `w_idx` in clog2(N_IN+1): write index
- `w_data` in W: write data
- `rd_idx` in clog2(N_IN+1): readback index
- `rd_data` out W: combinational read of weight `rd_idx`; 0 if rd_idx > N_IN
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at the end of a transaction
- `y` out W: activation output, held until the next `done`
- `err` out W: target − y, updated only in train transactions, held otherwise

## Operation
- States: IDLE → MAC → ACT → (UPDATE if train) → FIN → IDLE.
- IDLE: if `start` is high, latch inputs, load acc = bias, set i = 0, go to MAC. If `w_load` is high and w_idx ≤ N_IN, write the weight. When both are high in the same cycle, the write lands at the same edge and the transaction uses the new value.
- MAC: acc = sat(acc + ((w[i]*x[i]) >>> FRAC)). The product is a full 2W-bit signed value; the arithmetic shift truncates toward −∞; sat clamps to [−2^(W−1), 2^(W−1)−1]. Runs for N_IN cycles.
- ACT, one cycle, registers `y`:
  - Step: ONE if acc ≥ 0, else 0.
  - Sigmoid: clamp(ONE/2 + (acc >>> 2), 0, ONE).
  - Tanh: clamp(acc, −ONE, ONE).
  - ReLU: max(acc, 0).
- In a train transaction, ACT also registers err = sat(target − y).
- UPDATE, N_IN+1 cycles, one weight per cycle:
  - i < N_IN: w[i] = sat(w[i] + ((err*x[i] >>> FRAC) >>> LR_SHIFT)).
  - i = N_IN: bias = sat(bias + (err >>> LR_SHIFT)).
- FIN: assert `done` for one cycle, then go to IDLE.
- While `busy` is high, `start` and `w_load` are ignored; they are dropped, not queued.
- Reset (asynchronous, any state): state IDLE, all weights and bias 0, acc 0, y 0, err 0, busy 0, done 0. A transaction in flight when reset asserts is abandoned and produces no `done`.

## Timing
- `start` is sampled at edge k. `busy` is high from k+1 until `done`.
- Inference: `done` and the new `y` are visible in cycle k+N_IN+2.
- Training: `done` is visible in cycle k+2N_IN+3. Updated weights are readable on `rd_data` in that same cycle.
- A new `start` can be accepted in the first IDLE cycle after `done`, giving a throughput of N_IN+3 (infer) or 2N_IN+4 (train) cycles.
- `rd_data` has zero latency; a `w_load` write is visible on `rd_data` the cycle after the write edge.

## Test plan
All values in hex use the default parameters (W=32, FRAC=16, ONE=0x10000).
- Reset: assert `rst_n`=0 mid-MAC → busy=0, done=0, y=0, rd_data=0 for all indices; no `done` pulse follows release.
- ReLU inference: w = [1.0, 2.0, −1.0, 0.5], bias 0.25, x = [1, 1, 1, 2] → y=0x34000 (3.25), `done` at k+6; `start` pulsed while busy is ignored.
- Activations, acc = 2.0: Sigmoid → 0x10000; Tanh → 0x10000; Step → 0x10000. With acc = −1.0: Sigmoid → 0x4000; Tanh → 0xFFFF0000; ReLU → 0.
- Training: all weights 0, x = [1.0, 0, 0, 0], target 1.0, ReLU → y=0, err=0x10000, w0=0x1000, w1..w3=0, bias=0x1000, `done` at k+11.
- Saturation: w0 = x0 = 0x7FFF0000, other weights and bias 0 → acc=0x7FFFFFFF (no wrap); Tanh → 0x10000.
- Load/start collision: in IDLE, `w_load` with w_idx=4, w_data=0x20000 in the same cycle as `start` with all other weights 0 and ReLU → y=0x20000. A `w_load` to w_idx=5 changes no weight.
